// File: rtl/pi_client_nic_pkg.sv
// rtl/pi_client_nic_pkg.sv - shared defaults, injection source enum and saturating helper
package pi_client_nic_pkg;

  localparam int NIC_N   = 8;
  localparam int NIC_D_W = 32;

  typedef enum logic [1:0] {
    INJ_NONE,
    INJ_BOUNCE,
    INJ_TX
  } inj_src_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pi_client_nic_if.sv
// rtl/pi_client_nic_if.sv - client and leaf-switch link bundle of the pi client NIC
interface pi_client_nic_if #(
  parameter int A_W = 4,
  parameter int D_W = 32
);
  logic           c_tx_v;
  logic           c_tx_rdy;
  logic [A_W-1:0] c_tx_addr;
  logic [D_W-1:0] c_tx_data;
  logic           c_rx_v;
  logic           c_rx_rdy;
  logic [D_W-1:0] c_rx_data;
  logic           noc_o_v;
  logic [A_W-1:0] noc_o_addr;
  logic [D_W-1:0] noc_o_data;
  logic           noc_i_busy;
  logic           noc_i_v;
  logic [A_W-1:0] noc_i_addr;
  logic [D_W-1:0] noc_i_data;

  modport slave (
    input  c_tx_v, c_tx_addr, c_tx_data, c_rx_rdy,
    input  noc_i_busy, noc_i_v, noc_i_addr, noc_i_data,
    output c_tx_rdy, c_rx_v, c_rx_data, noc_o_v, noc_o_addr, noc_o_data
  );

  modport master (
    output c_tx_v, c_tx_addr, c_tx_data, c_rx_rdy,
    output noc_i_busy, noc_i_v, noc_i_addr, noc_i_data,
    input  c_tx_rdy, c_rx_v, c_rx_data, noc_o_v, noc_o_addr, noc_o_data
  );
endinterface

// File: rtl/pi_client_nic_fifo.sv
// rtl/pi_client_nic_fifo.sv - synchronous FIFO; a pop on a full FIFO frees room for a same-edge push
module pi_client_nic_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int P_W = $clog2(DEPTH);
  localparam int C_W = P_W + 1;

  logic [W-1:0]   mem_q [DEPTH];
  logic [P_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [C_W-1:0] cnt_q;
  logic           do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == C_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + P_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + P_W'(1);
      cnt_q <= cnt_q + C_W'(do_push) - C_W'(do_pop);
    end
  end

  // Contents need no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/pi_client_nic.sv
// rtl/pi_client_nic.sv - client NIC of a leaf pi switch: TX injection, RX ejection, misdelivery bounce
module pi_client_nic
  import pi_client_nic_pkg::*;
#(
  parameter int N    = NIC_N,
  parameter int A_W  = $clog2(N) + 1,
  parameter int D_W  = NIC_D_W,
  parameter int POSX = 0,
  parameter int TXD  = 4,
  parameter int RXD  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pi_client_nic_if.slave    bus,
  output logic              rx_ovf,
  output logic [7:0]        drop_cnt
);
  logic                 tx_full, tx_empty, tx_push, tx_pop;
  logic                 rx_full, rx_empty, rx_push, rx_pop;
  logic [A_W+D_W-1:0]   tx_head;
  logic [D_W-1:0]       rx_head;
  logic                 bnc_v_q, bnc_v_d;
  logic [A_W-1:0]       bnc_addr_q, bnc_addr_d;
  logic [D_W-1:0]       bnc_data_q, bnc_data_d;
  logic                 o_v_q, o_v_d;
  logic [A_W-1:0]       o_addr_q, o_addr_d;
  logic [D_W-1:0]       o_data_q, o_data_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           drop_q, drop_d;
  logic                 for_me, misdeliv, bnc_free, rx_drop, bnc_drop;
  inj_src_e             inj_src;

  assign for_me   = bus.noc_i_v & (bus.noc_i_addr == A_W'(POSX));
  assign misdeliv = bus.noc_i_v & (bus.noc_i_addr != A_W'(POSX));
  assign tx_push  = bus.c_tx_v & ~tx_full;
  assign rx_push  = for_me;
  assign rx_pop   = ~rx_empty & bus.c_rx_rdy;

  pi_client_nic_fifo #(.W(A_W + D_W), .DEPTH(TXD)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(tx_push), .push_data_i({bus.c_tx_addr, bus.c_tx_data}),
    .pop_i(tx_pop), .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  pi_client_nic_fifo #(.W(D_W), .DEPTH(RXD)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_i(rx_push), .push_data_i(bus.noc_i_data),
    .pop_i(rx_pop), .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  always_comb begin
    inj_src    = INJ_NONE;
    o_v_d      = 1'b0;
    o_addr_d   = o_addr_q;
    o_data_d   = o_data_q;
    bnc_v_d    = bnc_v_q;
    bnc_addr_d = bnc_addr_q;
    bnc_data_d = bnc_data_q;

    // Bounced packets outrank new traffic so misdeliveries drain first.
    if (!bus.noc_i_busy) begin
      if (bnc_v_q)        inj_src = INJ_BOUNCE;
      else if (!tx_empty) inj_src = INJ_TX;
    end
    tx_pop = (inj_src == INJ_TX);

    case (inj_src)
      INJ_BOUNCE: begin
        o_v_d    = 1'b1;
        o_addr_d = bnc_addr_q;
        o_data_d = bnc_data_q;
      end
      INJ_TX: begin
        o_v_d                = 1'b1;
        {o_addr_d, o_data_d} = tx_head;
      end
      default: ;
    endcase

    bnc_free = ~bnc_v_q | (inj_src == INJ_BOUNCE);
    if (inj_src == INJ_BOUNCE) bnc_v_d = 1'b0;
    if (misdeliv && bnc_free) begin
      bnc_v_d    = 1'b1;
      bnc_addr_d = bus.noc_i_addr;
      bnc_data_d = bus.noc_i_data;
    end

    bnc_drop = misdeliv & ~bnc_free;
    rx_drop  = for_me & rx_full & ~rx_pop;
    ovf_d    = ovf_q | rx_drop | bnc_drop;
    drop_d   = (rx_drop | bnc_drop) ? sat_inc8(drop_q) : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnc_v_q    <= 1'b0;
      bnc_addr_q <= '0;
      bnc_data_q <= '0;
      o_v_q      <= 1'b0;
      o_addr_q   <= '0;
      o_data_q   <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      bnc_v_q    <= bnc_v_d;
      bnc_addr_q <= bnc_addr_d;
      bnc_data_q <= bnc_data_d;
      o_v_q      <= o_v_d;
      o_addr_q   <= o_addr_d;
      o_data_q   <= o_data_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.c_tx_rdy   = ~tx_full;
  assign bus.c_rx_v     = ~rx_empty;
  assign bus.c_rx_data  = rx_head;
  assign bus.noc_o_v    = o_v_q;
  assign bus.noc_o_addr = o_addr_q;
  assign bus.noc_o_data = o_data_q;
  assign rx_ovf         = ovf_q;
  assign drop_cnt       = drop_q;
endmodule

// File: tb/tb_pi_client_nic.sv
// tb/tb_pi_client_nic.sv - randomized and directed bench for pi_client_nic against a queue-based model
module tb_pi_client_nic;
  localparam int A_W  = 4;
  localparam int D_W  = 32;
  localparam int POSX = 3;
  localparam int TXD  = 4;
  localparam int RXD  = 4;

  typedef struct packed {
    logic [A_W-1:0] addr;
    logic [D_W-1:0] data;
  } pkt_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_ovf;
  logic [7:0] drop_cnt;

  pi_client_nic_if #(.A_W(A_W), .D_W(D_W)) bus ();

  pi_client_nic #(
    .N(8), .A_W(A_W), .D_W(D_W), .POSX(POSX), .TXD(TXD), .RXD(RXD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .rx_ovf(rx_ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int pulses = 0;

  pkt_t           tx_q[$];
  logic [D_W-1:0] rx_q[$];
  bit             b_full;
  pkt_t           b_pkt;
  bit             m_o_v;
  pkt_t           m_o;
  int             m_drops;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    b_full  = 1'b0;
    m_o_v   = 1'b0;
    m_drops = 0;
  endtask

  task automatic model_step();
    pkt_t in_pkt;
    bit   take_tx, pop_rx;
    in_pkt  = {bus.noc_i_addr, bus.noc_i_data};
    take_tx = bus.c_tx_v && (tx_q.size() < TXD);
    pop_rx  = bus.c_rx_rdy && (rx_q.size() > 0);
    m_o_v   = 1'b0;
    if (!bus.noc_i_busy) begin
      if (b_full) begin
        m_o_v  = 1'b1;
        m_o    = b_pkt;
        b_full = 1'b0;
      end else if (tx_q.size() > 0) begin
        m_o_v = 1'b1;
        m_o   = tx_q.pop_front();
      end
    end
    if (take_tx) tx_q.push_back({bus.c_tx_addr, bus.c_tx_data});
    if (pop_rx) void'(rx_q.pop_front());
    if (bus.noc_i_v) begin
      if (int'(bus.noc_i_addr) == POSX) begin
        if (rx_q.size() < RXD) rx_q.push_back(bus.noc_i_data);
        else m_drops++;
      end else if (b_full) begin
        m_drops++;
      end else begin
        b_full = 1'b1;
        b_pkt  = in_pkt;
      end
    end
  endtask

  task automatic compare();
    chk("tx_rdy", bus.c_tx_rdy, tx_q.size() < TXD);
    chk("rx_v", bus.c_rx_v, rx_q.size() > 0);
    if (rx_q.size() > 0) chk("rx_data", bus.c_rx_data, rx_q[0]);
    chk("noc_o_v", bus.noc_o_v, m_o_v);
    if (m_o_v) chk("noc_o_pkt", {bus.noc_o_addr, bus.noc_o_data}, m_o);
    chk("rx_ovf", rx_ovf, m_drops > 0);
    chk("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
    if (bus.noc_o_v) pulses++;
  endtask

  task automatic drive(input bit tv, input logic [A_W-1:0] ta, input logic [D_W-1:0] td,
                       input bit rr, input bit busy, input bit iv,
                       input logic [A_W-1:0] ia, input logic [D_W-1:0] id);
    bus.c_tx_v     = tv;
    bus.c_tx_addr  = ta;
    bus.c_tx_data  = td;
    bus.c_rx_rdy   = rr;
    bus.noc_i_busy = busy;
    bus.noc_i_v    = iv;
    bus.noc_i_addr = ia;
    bus.noc_i_data = id;
  endtask

  // One clock: inputs applied at the falling edge, outputs compared at the next falling edge.
  task automatic cyc(input bit tv, input logic [A_W-1:0] ta, input logic [D_W-1:0] td,
                     input bit rr, input bit busy, input bit iv,
                     input logic [A_W-1:0] ia, input logic [D_W-1:0] id);
    drive(tv, ta, td, rr, busy, iv, ia, id);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_cyc();
    cyc(1'($urandom_range(0, 1)), A_W'($urandom_range(0, 15)), $urandom,
        1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4),
        ($urandom_range(0, 1) == 1) ? A_W'(POSX) : A_W'($urandom_range(0, 15)), $urandom);
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    chk("rst_noc_o_v", bus.noc_o_v, 0);
    chk("rst_rx_v", bus.c_rx_v, 0);
    chk("rst_rx_ovf", rx_ovf, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_tx_rdy", bus.c_tx_rdy, 1);
    compare();
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    model_reset();
    @(negedge clk);
    reset_mid();
    chk("rst_noc_o_pkt", {bus.noc_o_addr, bus.noc_o_data}, 0);

    cyc(1'b1, A_W'(5), 32'hA5, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("lat_e0_v", bus.noc_o_v, 0);
    idle();
    chk("lat_e1_v", bus.noc_o_v, 1);
    chk("lat_e1_pkt", {bus.noc_o_addr, bus.noc_o_data}, {4'd5, 32'hA5});
    idle();
    chk("lat_e2_v", bus.noc_o_v, 0);

    pulses = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1, A_W'(i), 32'h100 + i, 1'b0, 1'b1, 1'b0, '0, '0);
    repeat (10) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    chk("stall_pulses", pulses, 0);
    chk("stall_tx_rdy", bus.c_tx_rdy, 0);
    repeat (5) idle();
    chk("stall_release_pulses", pulses, 4);

    cyc(1'b1, A_W'(2), 32'h11, 1'b0, 1'b1, 1'b0, '0, '0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, A_W'(6), 32'h22);
    idle();
    chk("bnc_first", {bus.noc_o_v, bus.noc_o_data}, {1'b1, 32'h22});
    idle();
    chk("bnc_second", {bus.noc_o_v, bus.noc_o_data}, {1'b1, 32'h11});

    repeat (20) rand_cyc();
    reset_mid();

    for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, A_W'(POSX), $urandom);
    chk("ovf_flag", rx_ovf, 1);
    chk("ovf_drop_cnt", drop_cnt, 2);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, A_W'(POSX), $urandom);
    chk("ovf_pop_push_no_drop", drop_cnt, 2);
    repeat (300) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, A_W'(POSX), $urandom);
    chk("drop_cnt_sat", drop_cnt, 255);

    reset_mid();
    repeat (600) rand_cyc();
    repeat (40) reset_mid_free_check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Drain with the client accepting and the link free so every stored packet is seen.
  task automatic reset_mid_free_check();
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask
endmodule
